// File: rtl/sync_fifo_pkg.sv
// sync_fifo_pkg
//   Shared definitions for the parametrised synchronous FIFO:
//   - ptr_width / cnt_width : derive pointer and occupancy widths from DEPTH
//   - DEF_* constants       : default geometry and threshold settings
//   - op_t / op_classify    : per-cycle operation class (idle/write/read/both)
//   - fifo_flags_t          : bundle of the decoded status flags
package sync_fifo_pkg;

  localparam int DEF_WIDTH     = 8;
  localparam int DEF_DEPTH     = 16;
  // almost_full default sits this many entries below DEPTH
  localparam int DEF_AF_MARGIN = 2;
  localparam int DEF_AE_LEVEL  = 2;

  // Encoding is {rd, wr} so op_classify is a plain concatenation.
  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_WR   = 2'b01,
    OP_RD   = 2'b10,
    OP_RW   = 2'b11
  } op_t;

  typedef struct packed {
    logic full;
    logic empty;
    logic almost_full;
    logic almost_empty;
  } fifo_flags_t;

  // Pointer indexes DEPTH entries.
  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Count needs one more bit than the pointer so that DEPTH itself fits.
  function automatic int cnt_width(input int depth);
    return ptr_width(depth) + 1;
  endfunction

  function automatic op_t op_classify(input logic wr, input logic rd);
    return op_t'({rd, wr});
  endfunction

endpackage

// File: rtl/fifo_ptr_ctr.sv
// fifo_ptr_ctr
//   Wrap-around pointer register. Increments by one when i_inc is high and
//   wraps naturally from 2**PW-1 to 0 (DEPTH is a power of two, so the
//   pointer width alone implements the modulo).
// Ports:
//   i_clock : rising-edge clock
//   i_reset : synchronous active-high reset, clears the pointer
//   i_inc   : advance the pointer this cycle
//   o_ptr   : current pointer value
module fifo_ptr_ctr #(
  parameter int PW = 4
) (
  input  logic          i_clock,
  input  logic          i_reset,
  input  logic          i_inc,
  output logic [PW-1:0] o_ptr
);

  logic [PW-1:0] r_ptr;

  always_ff @(posedge i_clock) begin
    if (i_reset)    r_ptr <= '0;
    else if (i_inc) r_ptr <= r_ptr + 1'b1;
  end

  assign o_ptr = r_ptr;

endmodule

// File: rtl/sync_fifo_param.sv
// sync_fifo_param
//   Parametrised single-clock FIFO using the full DEPTH capacity, with
//   simultaneous read/write, occupancy output, programmable almost-full /
//   almost-empty flags and one-cycle overflow/underflow pulses.
//   Read data is registered: dout updates the cycle after an accepted read
//   and otherwise holds its last value.
// Ports:
//   i_clock        : rising-edge clock
//   i_reset        : synchronous active-high reset (wins over wr/rd)
//   i_wr, i_din    : write request and data
//   i_rd           : read request
//   o_dout         : registered read data
//   o_full/o_empty : count == DEPTH / count == 0
//   o_almost_full  : count >= AF_LEVEL
//   o_almost_empty : count <= AE_LEVEL
//   o_count        : occupancy, $clog2(DEPTH)+1 bits
//   o_overflow     : pulse, a write was rejected the previous cycle
//   o_underflow    : pulse, a read was rejected the previous cycle
// Optional: define SYNC_FIFO_ASSERT_EN to compile in concurrent assertions
//   and elaboration-time parameter checks.
module sync_fifo_param
  import sync_fifo_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int AF_LEVEL = DEPTH - DEF_AF_MARGIN,
  parameter int AE_LEVEL = DEF_AE_LEVEL
) (
  input  logic                        i_clock,
  input  logic                        i_reset,
  input  logic                        i_wr,
  input  logic                        i_rd,
  input  logic [WIDTH-1:0]            i_din,
  output logic [WIDTH-1:0]            o_dout,
  output logic                        o_full,
  output logic                        o_empty,
  output logic                        o_almost_full,
  output logic                        o_almost_empty,
  output logic [cnt_width(DEPTH)-1:0] o_count,
  output logic                        o_overflow,
  output logic                        o_underflow
);

  localparam int PW = ptr_width(DEPTH);
  localparam int CW = cnt_width(DEPTH);

  localparam logic [CW-1:0] C_DEPTH   = CW'(DEPTH);
  localparam logic [CW-1:0] C_DEPTHM1 = CW'(DEPTH - 1);
  localparam logic [CW-1:0] C_AF      = CW'(AF_LEVEL);
  localparam logic [CW-1:0] C_AE      = CW'(AE_LEVEL);

  // Storage is deliberately not reset.
  logic [WIDTH-1:0] r_mem [DEPTH];

  logic [PW-1:0]    w_wrptr;
  logic [PW-1:0]    w_rdptr;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_dout;
  logic             r_overflow;
  logic             r_underflow;

  fifo_flags_t      w_flags;
  logic             w_wr_ok;
  logic             w_rd_ok;
  op_t              w_op;

  // Flags decode straight off the registered count.
  always_comb begin
    w_flags              = '0;
    w_flags.full         = (r_count == C_DEPTH);
    w_flags.empty        = (r_count == '0);
    w_flags.almost_full  = (r_count >= C_AF);
    w_flags.almost_empty = (r_count <= C_AE);
  end

  // A write into a full FIFO is still accepted when a read frees the slot in
  // the same cycle. Reset masks both so a request coincident with reset
  // touches neither pointers nor memory.
  assign w_wr_ok = i_wr & (~w_flags.full | i_rd) & ~i_reset;
  assign w_rd_ok = i_rd & ~w_flags.empty & ~i_reset;
  assign w_op    = op_classify(w_wr_ok, w_rd_ok);

  fifo_ptr_ctr #(.PW(PW)) u_wrptr (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_inc   (w_wr_ok),
    .o_ptr   (w_wrptr)
  );

  fifo_ptr_ctr #(.PW(PW)) u_rdptr (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_inc   (w_rd_ok),
    .o_ptr   (w_rdptr)
  );

  always_ff @(posedge i_clock) begin
    if (w_wr_ok) r_mem[w_wrptr] <= i_din;
  end

  // When full with wr & rd, rdptr == wrptr: the non-blocking read below
  // captures the old word before the write lands in the same slot.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_count     <= '0;
      r_dout      <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      case (w_op)
        OP_WR:   r_count <= r_count + 1'b1;
        OP_RD:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_rd_ok) r_dout <= r_mem[w_rdptr];
      r_overflow  <= i_wr & w_flags.full & ~i_rd;
      r_underflow <= i_rd & w_flags.empty;
    end
  end

  assign o_dout         = r_dout;
  assign o_full         = w_flags.full;
  assign o_empty        = w_flags.empty;
  assign o_almost_full  = w_flags.almost_full;
  assign o_almost_empty = w_flags.almost_empty;
  assign o_count        = r_count;
  assign o_overflow     = r_overflow;
  assign o_underflow    = r_underflow;

`ifdef SYNC_FIFO_ASSERT_EN
  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("sync_fifo_param: DEPTH must be a power of two >= 2");
  end
  if ((AF_LEVEL < 1) || (AF_LEVEL > DEPTH)) begin : g_bad_af
    $error("sync_fifo_param: AF_LEVEL must be in 1..DEPTH");
  end
  if ((AE_LEVEL < 0) || (AE_LEVEL > DEPTH - 1)) begin : g_bad_ae
    $error("sync_fifo_param: AE_LEVEL must be in 0..DEPTH-1");
  end

  a_reset_state: assert property (@(posedge i_clock)
    $past(i_reset) |-> (r_count == '0 && w_wrptr == '0 && w_rdptr == '0));

  a_count_max: assert property (@(posedge i_clock) disable iff (i_reset)
    r_count <= C_DEPTH);

  a_full_empty_excl: assert property (@(posedge i_clock) disable iff (i_reset)
    !(w_flags.full && w_flags.empty));

  a_becomes_full: assert property (@(posedge i_clock) disable iff (i_reset)
    (w_op == OP_WR && r_count == C_DEPTHM1) |=> w_flags.full);

  a_becomes_empty: assert property (@(posedge i_clock) disable iff (i_reset)
    (w_op == OP_RD && r_count == CW'(1)) |=> w_flags.empty);

  a_overflow_cause: assert property (@(posedge i_clock) disable iff (i_reset)
    r_overflow |-> $past(w_flags.full));
`endif

endmodule

// File: tb/tb_sync_fifo_param.sv
// tb_sync_fifo_param
//   Directed scenarios followed by a randomized phase, all checked every
//   cycle against a queue-based reference of the FIFO behaviour.
module tb_sync_fifo_param;
  import sync_fifo_pkg::*;

  localparam int W  = 8;
  localparam int D  = 16;
  localparam int AF = 14;
  localparam int AE = 2;

  logic         clk = 1'b0;
  logic         i_reset = 1'b0;
  logic         i_wr = 1'b0;
  logic         i_rd = 1'b0;
  logic [W-1:0] i_din = '0;
  logic [W-1:0] o_dout;
  logic         o_full, o_empty, o_almost_full, o_almost_empty;
  logic [4:0]   o_count;
  logic         o_overflow, o_underflow;

  always #5 clk = ~clk;

  sync_fifo_param #(.WIDTH(W), .DEPTH(D), .AF_LEVEL(AF), .AE_LEVEL(AE)) dut (
    .i_clock        (clk),
    .i_reset        (i_reset),
    .i_wr           (i_wr),
    .i_rd           (i_rd),
    .i_din          (i_din),
    .o_dout         (o_dout),
    .o_full         (o_full),
    .o_empty        (o_empty),
    .o_almost_full  (o_almost_full),
    .o_almost_empty (o_almost_empty),
    .o_count        (o_count),
    .o_overflow     (o_overflow),
    .o_underflow    (o_underflow)
  );

  // Reference model state
  logic [W-1:0] q[$];
  logic [W-1:0] m_dout = '0;
  logic         m_ovf  = 1'b0;
  logic         m_unf  = 1'b0;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // FIFO rules at the transaction level: a read takes the oldest entry if
  // there is one; a write lands if there is room after this cycle's read.
  task automatic model_edge(input logic w, input logic r, input logic rst, input logic [W-1:0] d);
    bit was_full, was_empty;
    if (rst) begin
      q.delete();
      m_dout = '0;
      m_ovf  = 1'b0;
      m_unf  = 1'b0;
    end else begin
      was_full  = (q.size() == D);
      was_empty = (q.size() == 0);
      m_ovf = w && was_full && !r;
      m_unf = r && was_empty;
      if (r && !was_empty) m_dout = q.pop_front();
      if (w && (!was_full || r)) q.push_back(d);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, "/count"}, 32'(o_count),        32'(q.size()));
    chk({tag, "/empty"}, 32'(o_empty),        32'(q.size() == 0));
    chk({tag, "/full"},  32'(o_full),         32'(q.size() == D));
    chk({tag, "/af"},    32'(o_almost_full),  32'(q.size() >= AF));
    chk({tag, "/ae"},    32'(o_almost_empty), 32'(q.size() <= AE));
    chk({tag, "/dout"},  32'(o_dout),         32'(m_dout));
    chk({tag, "/ovf"},   32'(o_overflow),     32'(m_ovf));
    chk({tag, "/unf"},   32'(o_underflow),    32'(m_unf));
  endtask

  // One clock of stimulus: drive, let the edge happen, update the model,
  // then sample on the falling edge.
  task automatic step(input string tag, input op_t op, input logic [W-1:0] d, input logic rst);
    logic [1:0] b;
    b       = op;
    i_wr    = b[0];
    i_rd    = b[1];
    i_din   = d;
    i_reset = rst;
    @(posedge clk);
    model_edge(b[0], b[1], rst, d);
    @(negedge clk);
    check_all(tag);
  endtask

  initial begin
    logic [W-1:0] v;
    int pw, pr;
    op_t op;

    // Reset then idle
    step("rst", OP_IDLE, '0, 1'b1);
    step("rst", OP_IDLE, '0, 1'b1);
    step("idle", OP_IDLE, '0, 1'b0);
    chk("reset_empty", 32'(o_empty), 32'd1);
    chk("reset_ae", 32'(o_almost_empty), 32'd1);

    // Fill 0x01..0x10, thresholds checked on every step by check_all
    for (int i = 1; i <= D; i++) begin
      v = W'(i);
      step("fill", OP_WR, v, 1'b0);
    end
    chk("full_after16", 32'(o_full), 32'd1);
    chk("count16", 32'(o_count), 32'd16);

    // Rejected write into a full FIFO
    step("ovf", OP_WR, 8'hAA, 1'b0);
    chk("ovf_pulse", 32'(o_overflow), 32'd1);
    step("ovf_clr", OP_IDLE, '0, 1'b0);
    chk("ovf_one_cycle", 32'(o_overflow), 32'd0);

    // Drain in order, 0xAA must never appear
    for (int i = 1; i <= D; i++) begin
      step("drain", OP_RD, '0, 1'b0);
      chk("drain_data", 32'(o_dout), 32'(i));
    end

    // Read of an empty FIFO
    step("unf", OP_RD, '0, 1'b0);
    chk("unf_pulse", 32'(o_underflow), 32'd1);
    chk("unf_dout_hold", 32'(o_dout), 32'h10);
    step("unf_clr", OP_IDLE, '0, 1'b0);

    // Full with simultaneous wr & rd
    for (int i = 1; i <= D; i++) begin
      v = W'(i);
      step("fill2", OP_WR, v, 1'b0);
    end
    step("full_rw", OP_RW, 8'h55, 1'b0);
    chk("full_rw_dout", 32'(o_dout), 32'h01);
    chk("full_rw_count", 32'(o_count), 32'd16);
    for (int i = 0; i < D; i++) step("drain2", OP_RD, '0, 1'b0);
    chk("last_is_55", 32'(o_dout), 32'h55);

    // Empty with wr & rd: write lands, read rejected
    step("empty_rw", OP_RW, 8'h3C, 1'b0);
    chk("empty_rw_count", 32'(o_count), 32'd1);
    chk("empty_rw_unf", 32'(o_underflow), 32'd1);
    step("drain3", OP_RD, '0, 1'b0);
    chk("empty_rw_data", 32'(o_dout), 32'h3C);

    // Reset coincident with a write drops the write
    for (int i = 0; i < 14; i++) step("pre_rst", OP_WR, W'($urandom), 1'b0);
    step("rst_wr", OP_WR, 8'h77, 1'b1);
    chk("rst_wr_count", 32'(o_count), 32'd0);
    chk("rst_wr_empty", 32'(o_empty), 32'd1);
    step("post_rst", OP_RD, '0, 1'b0);

    // Randomized traffic with alternating fill/drain bias and rare resets
    for (int ph = 0; ph < 12; ph++) begin
      pw = (ph % 2 == 0) ? 80 : 25;
      pr = (ph % 2 == 0) ? 25 : 80;
      for (int c = 0; c < 60; c++) begin
        op = op_classify($urandom_range(0, 99) < pw, $urandom_range(0, 99) < pr);
        step("rand", op, W'($urandom), $urandom_range(0, 199) == 0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
